mem_arbiter: RTL



---
 rtl/mem_arbiter_if.sv | 18 +
 rtl/mem_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: packed per-port request/write
// channels plus the shared read-return channel.
interface mem_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
);
  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        we;
  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS*DATA_W-1:0] wdata;
  logic [NUM_PORTS-1:0]        gnt;
  logic [NUM_PORTS-1:0]        rvalid;
  logic [DATA_W-1:0]           rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// N-port arbiter onto a single synchronous RAM port: one access issued per
// cycle, read data returned in grant order to the originating port.
module mem_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int RD_LATENCY  = 1,
  parameter int ROUND_ROBIN = 1
) (
  input  logic              clock,
  input  logic              reset,
  mem_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q
);
  localparam int IDX_W = $clog2(NUM_PORTS);

  logic [IDX_W-1:0]     pointer_r;
  logic [NUM_PORTS-1:0] gnt_s;
  logic [IDX_W-1:0]     gnt_idx_s;
  logic                 gnt_any_s;
  logic [IDX_W-1:0]     scan_base_s;
  logic [RD_LATENCY-1:0] rd_valid_r;
  logic [IDX_W-1:0]     rd_port_r [RD_LATENCY];
  logic [NUM_PORTS-1:0] rvalid_r;

  function automatic logic [IDX_W-1:0] port_at(input logic [IDX_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    sum = (sum >= NUM_PORTS) ? (sum - NUM_PORTS) : sum;
    return IDX_W'(sum);
  endfunction

  function automatic logic [NUM_PORTS-1:0] onehot(input logic en, input logic [IDX_W-1:0] idx);
    logic [NUM_PORTS-1:0] v;
    v      = '0;
    v[idx] = en;
    return v;
  endfunction

  assign scan_base_s = (ROUND_ROBIN != 0) ? pointer_r : '0;

  // Same-cycle grant: first requesting port scanning upward from the base.
  always_comb begin
    gnt_idx_s = '0;
    gnt_any_s = 1'b0;
    if (!reset) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (!gnt_any_s && bus.req[port_at(scan_base_s, j)]) begin
          gnt_any_s = 1'b1;
          gnt_idx_s = port_at(scan_base_s, j);
        end else begin
          gnt_any_s = gnt_any_s;
        end
      end
    end else begin
      gnt_any_s = 1'b0;
    end
    gnt_s = onehot(gnt_any_s, gnt_idx_s);
  end

  // Rotating pointer moves just past the last granted port.
  always_ff @(posedge clock) begin
    if (reset) begin
      pointer_r <= '0;
    end else if ((ROUND_ROBIN != 0) && gnt_any_s) begin
      pointer_r <= port_at(gnt_idx_s, 1);
    end else begin
      pointer_r <= pointer_r;
    end
  end

  // Issue stage: address/data hold their last values when idle, only wren drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
    end else if (gnt_any_s) begin
      ram_address <= bus.addr[gnt_idx_s*ADDR_W +: ADDR_W];
      ram_data    <= bus.wdata[gnt_idx_s*DATA_W +: DATA_W];
      ram_wren    <= bus.we[gnt_idx_s];
    end else begin
      ram_wren    <= 1'b0;
    end
  end

  // Read tracking: the extra rvalid register covers the issue-stage cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_r <= '0;
      rvalid_r   <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        rd_port_r[i] <= '0;
      end
    end else begin
      rd_valid_r[0] <= gnt_any_s && !bus.we[gnt_idx_s];
      rd_port_r[0]  <= gnt_idx_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_valid_r[i] <= rd_valid_r[i-1];
        rd_port_r[i]  <= rd_port_r[i-1];
      end
      rvalid_r <= onehot(rd_valid_r[RD_LATENCY-1], rd_port_r[RD_LATENCY-1]);
    end
  end

  assign bus.gnt    = gnt_s;
  assign bus.rvalid = rvalid_r;
  assign bus.rdata  = ram_q;
endmodule
